// File: rtl/sort_seq_ctrl.sv
// Batch sorter: loads DEPTH words, bubble-sorts them through a shared
// external less-than comparator, then streams them out ascending.
module sort_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_lt,
  output logic             busy
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SORT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);
  localparam logic [IDXW-1:0] LAST_PASS = IDXW'(DEPTH - 2);

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_wr;
  logic [IDXW-1:0]  r_rd;
  logic [IDXW-1:0]  r_j;
  logic [IDXW-1:0]  r_pass;
  logic             r_swap;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [IDXW-1:0]  w_j1;
  logic             w_last_j;
  logic             w_done;

  assign w_j1     = r_j + IDXW'(1);
  assign w_last_j = (r_j == (LAST_PASS - r_pass));
  // Early exit: a pass with no swap (this compare included) means sorted.
  assign w_done   = !(r_swap || cmp_lt) || (r_pass == LAST_PASS);

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_DRAIN);
  assign busy      = (r_state == S_SORT);
  assign out_data  = out_valid ? r_mem[r_rd] : '0;
  assign cmp_a     = busy ? r_mem[w_j1] : '0;
  assign cmp_b     = busy ? r_mem[r_j] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_wr    <= '0;
      r_rd    <= '0;
      r_j     <= '0;
      r_pass  <= '0;
      r_swap  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_mem[r_wr] <= in_data;
            r_wr        <= r_wr + IDXW'(1);
            if (r_wr == LAST_IDX) begin
              r_wr    <= '0;
              r_j     <= '0;
              r_pass  <= '0;
              r_swap  <= 1'b0;
              r_state <= S_SORT;
            end
          end
        end
        S_SORT: begin
          if (cmp_lt) begin
            r_mem[r_j] <= r_mem[w_j1];
            r_mem[w_j1] <= r_mem[r_j];
            r_swap      <= 1'b1;
          end
          if (w_last_j) begin
            if (w_done) begin
              r_rd    <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_pass <= r_pass + IDXW'(1);
              r_j    <= '0;
              r_swap <= 1'b0;
            end
          end else begin
            r_j <= w_j1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_rd <= r_rd + IDXW'(1);
            if (r_rd == LAST_IDX) begin
              r_rd    <= '0;
              r_wr    <= '0;
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Randomized bench for sort_seq_ctrl against an array-level bubble-sort
// model; the comparator is modelled as a plain unsigned less-than.
module tb_sort_seq_ctrl;

  typedef logic [4:0] batch_t [8];

  logic       clk = 0;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_ready;
  logic [4:0] cmp_a;
  logic [4:0] cmp_b;
  logic       cmp_lt;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  int exp_q[$];
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  assign cmp_lt = (cmp_a < cmp_b);

  sort_seq_ctrl #(.WIDTH(5), .DEPTH(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt), .busy(busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Expected compare trace and sorted result for one batch.
  task automatic model(input batch_t v);
    int m[8];
    bit sw;
    int t;
    qa.delete(); qb.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      m[i] = int'(v[i]);
      exp_q.push_back(int'(v[i]));
    end
    exp_q.sort();
    for (int p = 0; p <= 6; p++) begin
      sw = 0;
      for (int j = 0; j <= 6 - p; j++) begin
        qa.push_back(m[j+1]);
        qb.push_back(m[j]);
        if (m[j+1] < m[j]) begin
          t = m[j]; m[j] = m[j+1]; m[j+1] = t;
          sw = 1;
        end
      end
      if (!sw) break;
    end
  endtask

  task automatic load(input batch_t v, input int gap);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 0;
        in_data  = 5'($urandom);
        @(negedge clk);
        if (g == 0) check("gap_nobusy", busy, 0);
      end
      in_valid = 1;
      in_data  = v[i];
      check("load_iready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 0;
    in_data  = 5'($urandom);
    check("sort_start", busy, 1);
  endtask

  task automatic run_sort();
    int cnt = 0;
    while (busy && cnt < 64) begin
      if (cnt < qa.size()) begin
        check("cmp_a", cmp_a, qa[cnt]);
        check("cmp_b", cmp_b, qb[cnt]);
      end
      check("sort_noiready", in_ready, 0);
      cnt++;
      @(negedge clk);
    end
    check("n_compares", cnt, qa.size());
    check("lat_ovalid", out_valid, 1);
  endtask

  task automatic drain(input bit toggle);
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    int c = 0;
    while (k < 8 && c < 200) begin
      out_ready = toggle ? pat[c % 4] : 1'b1;
      check("ovalid", out_valid, 1);
      check("odata", out_data, exp_q[k]);
      check("drain_noiready", in_ready, 0);
      if (out_ready) k++;
      c++;
      @(negedge clk);
    end
    out_ready = 0;
    check("n_handshakes", k, 8);
    check("iready_after", in_ready, 1);
    check("ovalid_after", out_valid, 0);
  endtask

  task automatic batch(input batch_t v, input int gap, input bit toggle);
    model(v);
    load(v, gap);
    run_sort();
    drain(toggle);
  endtask

  initial begin
    batch_t b;
    rst = 1; in_valid = 0; in_data = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_iready", in_ready, 1);
    check("rst_ovalid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmp_a", cmp_a, 0);
    check("rst_cmp_b", cmp_b, 0);
    check("rst_odata", out_data, 0);
    rst = 0;
    @(negedge clk);

    b = '{31, 30, 29, 28, 27, 26, 25, 24};
    batch(b, 0, 0);
    check("desc_len", qa.size(), 28);

    b = '{0, 1, 2, 3, 4, 5, 6, 7};
    batch(b, 0, 0);
    check("sorted_len", qa.size(), 7);

    b = '{5, 0, 31, 5, 0, 31, 17, 5};
    batch(b, 0, 1);

    for (int i = 0; i < 8; i++) b[i] = 5'($urandom);
    batch(b, 0, 1);
    for (int i = 0; i < 8; i++) b[i] = 5'($urandom);
    batch(b, 0, 0);

    b = '{31, 30, 29, 28, 27, 26, 25, 24};
    model(b);
    load(b, 0);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_iready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovalid", out_valid, 0);
    check("mid_rst_cmp_a", cmp_a, 0);

    b = '{3, 1, 2, 0, 7, 6, 5, 4};
    batch(b, 0, 0);

    for (int i = 0; i < 8; i++) b[i] = 5'($urandom);
    batch(b, 2, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) b[i] = 5'($urandom_range(0, 31));
      batch(b, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sort_seq_ctrl.md
Name: sort_seq_ctrl

Overview:
Sequential sorting controller that owns one external 5-bit less-than comparator and time-shares it across a small internal register bank.
- Accepts DEPTH unsigned words over a valid/ready input stream.
- Runs an early-exit bubble sort (ascending, stable), issuing one comparison per clock.
- Streams the sorted words out over a valid/ready output stream.
- Sits between the input capture logic and the comparator datapath; the top level wires cmp_a/cmp_b to the comparator inputs and the comparator's output bit 0 to cmp_lt.

Parameters:
WIDTH, 5, data word width; must match the comparator.
DEPTH, 8, words per sort batch; DEPTH >= 2.
IDXW, 3, index width; IDXW = clog2(DEPTH).

Ports:
clk  in  1  single system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  in_data is valid.
in_data  in  WIDTH  unsigned word to load.
in_ready  out  1  controller accepts a word this cycle.
out_valid  out  1  out_data holds a sorted word.
out_data  out  WIDTH  sorted word, ascending order.
out_ready  in  1  downstream accepts out_data.
cmp_a  out  WIDTH  comparator operand a.
cmp_b  out  WIDTH  comparator operand b.
cmp_lt  in  1  comparator result (a<b), combinational same cycle.
busy  out  1  high in SORT state.

Behaviour:
- Reset
  - On rst=1 at a clock edge: state=LOAD; write index, pass, j, rd index and swap flag cleared; mem entries cleared to 0.
  - Reset takes effect from any state, including mid-SORT and mid-DRAIN. A partial batch is discarded with no output.
  - Post-reset outputs: in_ready=1, out_valid=0, busy=0, cmp_a=cmp_b=0.
- Outputs
  - in_ready = (state==LOAD).
  - out_valid = (state==DRAIN).
  - busy = (state==SORT).
  - out_data = mem[rd] in DRAIN, else 0.
  - cmp_a = mem[j+1] and cmp_b = mem[j] in SORT, else 0.
- LOAD
  - On in_valid&&in_ready: mem[wr]<=in_data, wr++.
  - On the DEPTH-th accept: wr<=0, j<=0, pass<=0, swap flag<=0, next state SORT.
  - in_valid=0 stalls indefinitely.
- SORT (one compare per cycle)
  - If cmp_lt=1 (mem[j+1] < mem[j]): swap mem[j] and mem[j+1] at the edge and set the swap flag.
  - Equal values are never swapped (stable sort).
  - Pass p covers j = 0 .. DEPTH-2-p.
  - At the last j of a pass: if no swap occurred in the pass (including the current compare), or p == DEPTH-2, next state is DRAIN with rd<=0. Otherwise p++, j<=0, swap flag<=0.
- Latency (last input accept at edge T)
  - First compare is in cycle T+1.
  - Already-sorted input: 7 compare cycles; out_valid=1 from cycle T+8.
  - Worst case (strictly descending input): DEPTH*(DEPTH-1)/2 = 28 compares; out_valid=1 from cycle T+29.
- DRAIN
  - On out_valid&&out_ready: rd++.
  - After the DEPTH-th handshake: next state LOAD, wr=0. in_ready=1 in the following cycle.
  - out_ready=0 holds out_data stable.
  - LOAD and DRAIN never overlap; in_ready=0 throughout SORT and DRAIN.
- Arithmetic
  - All compares are unsigned WIDTH-bit, performed only by the external comparator.
  - No internal magnitude compare on data.
  - Index counters wrap only through the explicit resets above.

Test Plan:
1. Load 31,30,29,28,27,26,25,24 -> busy high exactly 28 cycles; output 24,25,26,27,28,29,30,31; out_valid first at T+29.
2. Load 0,1,2,3,4,5,6,7 -> busy high exactly 7 cycles; output unchanged order; out_valid first at T+8.
3. Load 5,0,31,5,0,31,17,5 (duplicates and boundary values) -> output 0,0,5,5,5,17,31,31; no out-of-range value on cmp_a/cmp_b.
4. Random batch with out_ready toggled 1,0,0,1 pattern -> out_data held stable while out_ready=0; exactly 8 handshakes, then in_ready=1 the next cycle; a second batch sorts correctly.
5. Assert rst for 1 cycle at the 10th SORT cycle of case 1 -> next cycle state LOAD: in_ready=1, busy=0, out_valid=0; a fresh batch of 3,1,2,0,7,6,5,4 yields 0..7.
6. in_valid gaps during LOAD (valid every 3rd cycle) -> only valid words captured; SORT starts the cycle after the 8th accept.
